// File: rtl/decode_ctrl.sv
//==============================================================================
// Module : decode_ctrl
// Brief  : RV32I decode/control FSM sequencing ALU, register file and LSU.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module decode_ctrl #(
  parameter int DATA_WIDTH       = 32,
  parameter int ALU_CONTROL_BITS = 4,
  parameter int LOG2_REGISTERS   = 5,
  parameter int BYTE_DATA_WIDTH  = DATA_WIDTH / 8,
  parameter int MEM_TIMEOUT      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        inst_valid,
  input  logic [DATA_WIDTH-1:0]       inst,
  input  logic [DATA_WIDTH-1:0]       pc,
  input  logic [DATA_WIDTH-1:0]       link,
  output logic                        inst_ready,
  output logic                        done,
  output logic                        branch_taken,
  output logic [DATA_WIDTH-1:0]       new_pc,
  output logic                        trap,
  output logic [1:0]                  trap_cause,
  output logic [LOG2_REGISTERS-1:0]   addr_rd,
  output logic [LOG2_REGISTERS-1:0]   addr_rs1,
  output logic [LOG2_REGISTERS-1:0]   addr_rs2,
  output logic                        rf_enable,
  output logic [1:0]                  rd_select,
  output logic [ALU_CONTROL_BITS-1:0] alu_control,
  output logic                        signed_flag,
  output logic                        select_imm,
  output logic                        select_pc,
  output logic [DATA_WIDTH-1:0]       imm,
  input  logic                        less_comp,
  input  logic                        equal_comp,
  input  logic [DATA_WIDTH-1:0]       q,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic                        mem_unsigned,
  output logic [BYTE_DATA_WIDTH-1:0]  mem_byte_enable,
  input  logic                        mem_valid
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] c_op_op     = 7'b0110011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;

  localparam logic [ALU_CONTROL_BITS-1:0] c_alu_add   = ALU_CONTROL_BITS'(0);
  localparam logic [ALU_CONTROL_BITS-1:0] c_alu_sub   = ALU_CONTROL_BITS'(1);
  localparam logic [ALU_CONTROL_BITS-1:0] c_alu_sll   = ALU_CONTROL_BITS'(2);
  localparam logic [ALU_CONTROL_BITS-1:0] c_alu_xor   = ALU_CONTROL_BITS'(3);
  localparam logic [ALU_CONTROL_BITS-1:0] c_alu_srl   = ALU_CONTROL_BITS'(4);
  localparam logic [ALU_CONTROL_BITS-1:0] c_alu_sra   = ALU_CONTROL_BITS'(5);
  localparam logic [ALU_CONTROL_BITS-1:0] c_alu_or    = ALU_CONTROL_BITS'(6);
  localparam logic [ALU_CONTROL_BITS-1:0] c_alu_and   = ALU_CONTROL_BITS'(7);
  localparam logic [ALU_CONTROL_BITS-1:0] c_alu_slt   = ALU_CONTROL_BITS'(8);
  localparam logic [ALU_CONTROL_BITS-1:0] c_alu_sltu  = ALU_CONTROL_BITS'(9);
  localparam logic [ALU_CONTROL_BITS-1:0] c_alu_passb = ALU_CONTROL_BITS'(10);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DECODE    = 3'd1,
    S_MEM       = 3'd2,
    S_PC_UPDATE = 3'd3,
    S_DONE      = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  state_t                       r_state, w_next;
  logic [DATA_WIDTH-1:0]        r_inst;
  logic [DATA_WIDTH-1:0]        r_pc;
  logic [CNT_W-1:0]             r_cnt;
  logic [BYTE_DATA_WIDTH-1:0]   r_be;
  logic                         r_taken;
  logic [DATA_WIDTH-1:0]        r_new_pc;
  logic [1:0]                   r_cause;

  logic [6:0]                   w_opcode;
  logic [2:0]                   w_f3;
  logic [6:0]                   w_f7;
  logic                         w_rd_nz;
  logic                         w_is_store;
  logic                         w_is_jalr;
  logic [1:0]                   w_size;
  logic                         w_ls_bad;
  logic                         w_misaligned;
  logic [BYTE_DATA_WIDTH-1:0]   w_be_base;
  logic [BYTE_DATA_WIDTH-1:0]   w_be_val;
  logic [ALU_CONTROL_BITS-1:0]  w_alu_arith;
  logic                         w_is_slt;
  logic                         w_br_cond;
  logic [31:0]                  w_imm32;
  logic [DATA_WIDTH-1:0]        w_new_pc;
  logic                         w_taken_load, w_taken_val;
  logic                         w_cause_load;
  logic [1:0]                   w_cause_val;
  logic                         w_pc_load;
  logic                         w_be_load;
  logic                         w_unused;

  assign w_opcode   = r_inst[6:0];
  assign w_f3       = r_inst[14:12];
  assign w_f7       = r_inst[31:25];
  assign w_rd_nz    = |r_inst[11:7];
  assign w_is_store = (w_opcode == c_op_store);
  assign w_is_jalr  = (w_opcode == c_op_jalr);
  assign w_size     = w_f3[1:0];

  assign addr_rd      = r_inst[11:7];
  assign addr_rs1     = r_inst[19:15];
  assign addr_rs2     = r_inst[24:20];
  assign branch_taken = r_taken;
  assign new_pc       = r_new_pc;
  assign trap_cause   = r_cause;

  // pc and link only feed the datapath muxes outside this block
  assign w_unused = ^{r_pc, link};

  // Size 11, unsigned stores and LWU do not exist in RV32I
  assign w_ls_bad     = (w_size == 2'b11) || (w_f3[2] && (w_is_store || w_size == 2'b10));
  assign w_misaligned = ((w_size == 2'b01) && q[0]) || ((w_size == 2'b10) && (q[1:0] != 2'b00));
  assign w_be_base    = (w_size == 2'b00) ? BYTE_DATA_WIDTH'(4'h1) :
                        (w_size == 2'b01) ? BYTE_DATA_WIDTH'(4'h3) : BYTE_DATA_WIDTH'(4'hF);
  assign w_be_val     = w_be_base << q[1:0];

  assign w_new_pc = w_is_jalr ? (q & ~{{(DATA_WIDTH-1){1'b0}}, 1'b1}) : q;
  assign w_is_slt = (w_f3 == 3'b010) || (w_f3 == 3'b011);
  assign w_br_cond = (w_f3[2:1] == 2'b00) ? (equal_comp ^ w_f3[0]) : (less_comp ^ w_f3[0]);

  always_comb begin
    w_alu_arith = c_alu_add;
    case (w_f3)
      3'b000:  w_alu_arith = ((w_opcode == c_op_op) && w_f7[5]) ? c_alu_sub : c_alu_add;
      3'b001:  w_alu_arith = c_alu_sll;
      3'b010:  w_alu_arith = c_alu_slt;
      3'b011:  w_alu_arith = c_alu_sltu;
      3'b100:  w_alu_arith = c_alu_xor;
      3'b101:  w_alu_arith = w_f7[5] ? c_alu_sra : c_alu_srl;
      3'b110:  w_alu_arith = c_alu_or;
      default: w_alu_arith = c_alu_and;
    endcase
  end

  always_comb begin
    w_imm32 = 32'h0;
    case (w_opcode)
      c_op_imm, c_op_load, c_op_jalr:
        w_imm32 = {{20{r_inst[31]}}, r_inst[31:20]};
      c_op_store:
        w_imm32 = {{20{r_inst[31]}}, r_inst[31:25], r_inst[11:7]};
      c_op_branch:
        w_imm32 = {{19{r_inst[31]}}, r_inst[31], r_inst[7], r_inst[30:25], r_inst[11:8], 1'b0};
      c_op_lui, c_op_auipc:
        w_imm32 = {r_inst[31:12], 12'h000};
      c_op_jal:
        w_imm32 = {{11{r_inst[31]}}, r_inst[31], r_inst[19:12], r_inst[20], r_inst[30:21], 1'b0};
      default:
        w_imm32 = 32'h0;
    endcase
    imm = DATA_WIDTH'($signed(w_imm32));
  end

  always_comb begin
    w_next          = r_state;
    inst_ready      = 1'b0;
    done            = 1'b0;
    trap            = 1'b0;
    rf_enable       = 1'b0;
    rd_select       = 2'b00;
    alu_control     = c_alu_add;
    signed_flag     = 1'b0;
    select_imm      = 1'b0;
    select_pc       = 1'b0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_unsigned    = 1'b0;
    mem_byte_enable = '0;
    w_taken_load    = 1'b0;
    w_taken_val     = 1'b0;
    w_cause_load    = 1'b0;
    w_cause_val     = 2'd0;
    w_pc_load       = 1'b0;
    w_be_load       = 1'b0;

    case (r_state)
      S_IDLE: begin
        inst_ready = rst;
        if (inst_valid) w_next = S_DECODE;
      end

      S_DECODE: begin
        case (w_opcode)
          c_op_op, c_op_imm: begin
            if ((w_opcode == c_op_op) && (w_f7 != 7'h00) && (w_f7 != 7'h20)) begin
              w_cause_load = 1'b1;
              w_next       = S_TRAP;
            end else begin
              alu_control = w_alu_arith;
              select_imm  = (w_opcode == c_op_imm);
              signed_flag = w_is_slt && !w_f3[0];
              rd_select   = w_is_slt ? 2'b01 : 2'b00;
              rf_enable   = w_rd_nz;
              w_next      = S_DONE;
            end
          end
          c_op_lui: begin
            alu_control = c_alu_passb;
            select_imm  = 1'b1;
            rf_enable   = w_rd_nz;
            w_next      = S_DONE;
          end
          c_op_auipc: begin
            select_pc  = 1'b1;
            select_imm = 1'b1;
            rf_enable  = w_rd_nz;
            w_next     = S_DONE;
          end
          c_op_load, c_op_store: begin
            select_imm = 1'b1;
            w_next     = S_TRAP;
            w_cause_load = 1'b1;
            if (w_ls_bad) begin
              w_cause_val = 2'd0;
            end else if (w_misaligned) begin
              w_cause_val = 2'd1;
            end else begin
              w_cause_load = 1'b0;
              w_be_load    = 1'b1;
              w_next       = S_MEM;
            end
          end
          c_op_branch: begin
            alu_control = c_alu_sub;
            signed_flag = !w_f3[1];
            if (w_f3[2:1] == 2'b01) begin
              w_cause_load = 1'b1;
              w_next       = S_TRAP;
            end else begin
              w_taken_load = 1'b1;
              w_taken_val  = w_br_cond;
              w_next       = w_br_cond ? S_PC_UPDATE : S_DONE;
            end
          end
          c_op_jal, c_op_jalr: begin
            rd_select    = 2'b11;
            rf_enable    = w_rd_nz;
            w_taken_load = 1'b1;
            w_taken_val  = 1'b1;
            w_next       = S_PC_UPDATE;
          end
          default: begin
            w_cause_load = 1'b1;
            w_next       = S_TRAP;
          end
        endcase
      end

      S_PC_UPDATE: begin
        select_imm = 1'b1;
        select_pc  = !w_is_jalr;
        w_pc_load  = 1'b1;
        w_next     = S_DONE;
      end

      S_MEM: begin
        mem_req         = 1'b1;
        mem_we          = w_is_store;
        mem_unsigned    = !w_is_store && w_f3[2];
        mem_byte_enable = r_be;
        // A completion in the final permitted cycle beats the timeout
        if (mem_valid) begin
          if (!w_is_store) begin
            rf_enable = w_rd_nz;
            rd_select = 2'b10;
          end
          w_next = S_DONE;
        end else if (r_cnt == c_cnt_last) begin
          w_cause_load = 1'b1;
          w_cause_val  = 2'd2;
          w_next       = S_TRAP;
        end
      end

      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end

      S_TRAP: begin
        trap   = 1'b1;
        w_next = S_IDLE;
      end

      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_inst   <= '0;
      r_pc     <= '0;
      r_cnt    <= '0;
      r_be     <= '0;
      r_taken  <= 1'b0;
      r_new_pc <= '0;
      r_cause  <= 2'd0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && inst_valid) begin
        r_inst  <= inst;
        r_pc    <= pc;
        r_taken <= 1'b0;
        r_cause <= 2'd0;
      end
      if (w_taken_load) r_taken  <= w_taken_val;
      if (w_cause_load) r_cause  <= w_cause_val;
      if (w_pc_load)    r_new_pc <= w_new_pc;
      if (w_be_load)    r_be     <= w_be_val;
      r_cnt <= (r_state == S_MEM) ? r_cnt + 1'b1 : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_ctrl.sv
//==============================================================================
// Module : tb_decode_ctrl
// Brief  : Directed scoreboard bench for decode_ctrl.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic [31:0] inst, pc, link;
  logic        inst_ready, done, branch_taken, trap;
  logic [31:0] new_pc;
  logic [1:0]  trap_cause;
  logic [4:0]  addr_rd, addr_rs1, addr_rs2;
  logic        rf_enable;
  logic [1:0]  rd_select;
  logic [3:0]  alu_control;
  logic        signed_flag, select_imm, select_pc;
  logic [31:0] imm;
  logic        less_comp, equal_comp;
  logic [31:0] q;
  logic        mem_req, mem_we, mem_unsigned;
  logic [3:0]  mem_byte_enable;
  logic        mem_valid;

  decode_ctrl #(
    .DATA_WIDTH(32), .ALU_CONTROL_BITS(4), .LOG2_REGISTERS(5),
    .BYTE_DATA_WIDTH(4), .MEM_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst), .pc(pc), .link(link),
    .inst_ready(inst_ready), .done(done), .branch_taken(branch_taken), .new_pc(new_pc),
    .trap(trap), .trap_cause(trap_cause), .addr_rd(addr_rd), .addr_rs1(addr_rs1),
    .addr_rs2(addr_rs2), .rf_enable(rf_enable), .rd_select(rd_select),
    .alu_control(alu_control), .signed_flag(signed_flag), .select_imm(select_imm),
    .select_pc(select_pc), .imm(imm), .less_comp(less_comp), .equal_comp(equal_comp),
    .q(q), .mem_req(mem_req), .mem_we(mem_we), .mem_unsigned(mem_unsigned),
    .mem_byte_enable(mem_byte_enable), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        is_trap;
    logic [1:0]  cause;
    logic        taken;
    logic [31:0] npc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;
  int          cyc = 0;
  logic [31:0] model_npc = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  // Offer one instruction in IDLE and record what its retirement must look like
  task automatic issue(input logic [31:0] i, input logic [31:0] p, input string tag,
                       input logic is_trap, input logic [1:0] cause, input logic taken,
                       input int lat);
    exp_t e;
    #1;
    chk({tag, ":ready"}, inst_ready, 1);
    inst_valid = 1'b1;
    inst = i;
    pc = p;
    link = p + 32'd4;
    cyc = 0;
    e.tag = tag; e.is_trap = is_trap; e.cause = cause;
    e.taken = taken; e.npc = model_npc; e.lat = lat;
    sb.push_back(e);
    tick();
    inst_valid = 1'b0;
    inst = $urandom;
    pc = $urandom;
  endtask

  task automatic retire(input int budget);
    exp_t e;
    int   n;
    n = 0;
    #1;
    while (!(done || trap) && n < budget) begin
      tick();
      #1;
      n++;
    end
    if (sb.size() == 0) begin
      n_total++;
      n_fail++;
      $error("FAIL scoreboard: retire observed with empty queue");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ":done"}, done, !e.is_trap);
      chk({e.tag, ":trap"}, trap, e.is_trap);
      chk({e.tag, ":cause"}, trap_cause, e.cause);
      chk({e.tag, ":taken"}, branch_taken, e.taken);
      chk({e.tag, ":new_pc"}, new_pc, e.npc);
      chk({e.tag, ":latency"}, cyc, e.lat);
      chk({e.tag, ":rf_quiet"}, rf_enable, 0);
      chk({e.tag, ":req_quiet"}, mem_req, 0);
    end
    tick();
  endtask

  initial begin
    int reqc;
    rst = 1'b0; inst_valid = 1'b0; inst = 0; pc = 0; link = 0;
    less_comp = 1'b0; equal_comp = 1'b0; q = 0; mem_valid = 1'b0;

    #3;
    chk("rst:ready", inst_ready, 0);
    chk("rst:done", done, 0);
    chk("rst:trap", trap, 0);
    chk("rst:mem_req", mem_req, 0);
    chk("rst:rf_enable", rf_enable, 0);
    chk("rst:taken", branch_taken, 0);
    chk("rst:new_pc", new_pc, 0);
    chk("rst:imm", imm, 0);
    #10 rst = 1'b1;
    tick();
    chk("rel:ready", inst_ready, 1);

    // ADDI x1,x0,-5
    issue(32'hFFB00093, 32'h0, "addi", 0, 0, 0, 2);
    #1;
    chk("addi:imm", imm, 32'hFFFFFFFB);
    chk("addi:alu", alu_control, 0);
    chk("addi:rf", rf_enable, 1);
    chk("addi:sel_imm", select_imm, 1);
    chk("addi:rd", addr_rd, 1);
    chk("addi:rd_sel", rd_select, 0);
    tick(); retire(4);

    // SRAI x1,x1,2
    issue(32'h4020D093, 32'h4, "srai", 0, 0, 0, 2);
    #1;
    chk("srai:alu", alu_control, 5);
    chk("srai:sel_imm", select_imm, 1);
    chk("srai:imm", imm, 32'h402);
    chk("srai:rf", rf_enable, 1);
    chk("srai:rs1", addr_rs1, 1);
    tick(); retire(4);

    // SLTU x3,x1,x2
    issue(32'h0020B1B3, 32'h8, "sltu", 0, 0, 0, 2);
    #1;
    chk("sltu:alu", alu_control, 9);
    chk("sltu:rd_sel", rd_select, 1);
    chk("sltu:signed", signed_flag, 0);
    chk("sltu:sel_imm", select_imm, 0);
    chk("sltu:rs2", addr_rs2, 2);
    tick(); retire(4);

    // SLTI x3,x1,-1
    issue(32'hFFF0A193, 32'hC, "slti", 0, 0, 0, 2);
    #1;
    chk("slti:alu", alu_control, 8);
    chk("slti:signed", signed_flag, 1);
    chk("slti:rd_sel", rd_select, 1);
    tick(); retire(4);

    // SUB x5,x1,x2
    issue(32'h402082B3, 32'h10, "sub", 0, 0, 0, 2);
    #1;
    chk("sub:alu", alu_control, 1);
    tick(); retire(4);

    // OP with funct7 = 0x01 is not in the base set
    issue(32'h0220B1B3, 32'h14, "bad_f7", 1, 0, 0, 2);
    #1;
    chk("bad_f7:rf", rf_enable, 0);
    tick(); retire(4);

    // LUI x4,0x12345
    issue(32'h12345237, 32'h18, "lui", 0, 0, 0, 2);
    #1;
    chk("lui:alu", alu_control, 10);
    chk("lui:imm", imm, 32'h12345000);
    chk("lui:sel_imm", select_imm, 1);
    chk("lui:rf", rf_enable, 1);
    tick(); retire(4);

    // AUIPC x4,1
    issue(32'h00001217, 32'h1C, "auipc", 0, 0, 0, 2);
    #1;
    chk("auipc:sel_pc", select_pc, 1);
    chk("auipc:sel_imm", select_imm, 1);
    chk("auipc:alu", alu_control, 0);
    chk("auipc:imm", imm, 32'h1000);
    tick(); retire(4);

    // BLTU x1,x2,+8 taken
    model_npc = 32'h108;
    issue(32'h0020E463, 32'h100, "bltu_t", 0, 0, 1, 3);
    less_comp = 1'b1;
    #1;
    chk("bltu_t:signed", signed_flag, 0);
    chk("bltu_t:alu", alu_control, 1);
    chk("bltu_t:sel_pc_dec", select_pc, 0);
    tick();
    less_comp = 1'b0; q = 32'h108;
    #1;
    chk("bltu_t:sel_pc", select_pc, 1);
    chk("bltu_t:sel_imm", select_imm, 1);
    chk("bltu_t:alu_pcu", alu_control, 0);
    chk("bltu_t:imm", imm, 32'h8);
    tick(); q = 0; retire(4);
    #1;
    chk("bltu_t:taken_hold", branch_taken, 1);
    chk("bltu_t:npc_hold", new_pc, 32'h108);

    // BLTU not taken
    issue(32'h0020E463, 32'h100, "bltu_nt", 0, 0, 0, 2);
    less_comp = 1'b0;
    tick(); retire(4);

    // BNE x1,x2,-4 taken
    model_npc = 32'h1FC;
    issue(32'hFE209EE3, 32'h200, "bne", 0, 0, 1, 3);
    equal_comp = 1'b0;
    #1;
    chk("bne:imm", imm, 32'hFFFFFFFC);
    chk("bne:signed", signed_flag, 1);
    tick();
    q = 32'h1FC;
    tick(); q = 0; retire(4);

    // JALR x1,5(x2): target LSB cleared
    model_npc = 32'h2004;
    issue(32'h005100E7, 32'h300, "jalr", 0, 0, 1, 3);
    #1;
    chk("jalr:rd_sel", rd_select, 3);
    chk("jalr:rf", rf_enable, 1);
    tick();
    q = 32'h2005;
    #1;
    chk("jalr:sel_pc", select_pc, 0);
    chk("jalr:sel_imm", select_imm, 1);
    chk("jalr:imm", imm, 32'h5);
    tick(); q = 0; retire(4);

    // SB x2,0(x1) at 0x1003, completion on the third MEM cycle
    issue(32'h00208023, 32'h400, "sb", 0, 0, 0, 5);
    q = 32'h1003;
    #1;
    chk("sb:sel_imm", select_imm, 1);
    chk("sb:alu", alu_control, 0);
    chk("sb:req_dec", mem_req, 0);
    tick();
    #1;
    chk("sb:req", mem_req, 1);
    chk("sb:we", mem_we, 1);
    chk("sb:be", mem_byte_enable, 4'b1000);
    tick(); tick();
    mem_valid = 1'b1;
    #1;
    chk("sb:rf", rf_enable, 0);
    tick(); mem_valid = 1'b0; retire(4);

    // LH at an odd address traps before any request
    issue(32'h00109183, 32'h404, "lh_mis", 1, 1, 0, 2);
    q = 32'h1001;
    #1;
    chk("lh_mis:req", mem_req, 0);
    tick(); retire(4);

    // LBU x3,2(x1) at 0x1002
    issue(32'h0020C183, 32'h408, "lbu", 0, 0, 0, 3);
    q = 32'h1002;
    tick();
    mem_valid = 1'b1;
    #1;
    chk("lbu:unsigned", mem_unsigned, 1);
    chk("lbu:be", mem_byte_enable, 4'b0100);
    chk("lbu:we", mem_we, 0);
    chk("lbu:rf", rf_enable, 1);
    chk("lbu:rd_sel", rd_select, 2);
    tick(); mem_valid = 1'b0; retire(4);

    // LW with no completion: timeout
    issue(32'h0000A183, 32'h40C, "lw_to", 1, 2, 0, 18);
    q = 32'h1000;
    tick();
    #1;
    reqc = 0;
    while (mem_req && reqc < 40) begin
      reqc++;
      tick();
      #1;
    end
    chk("lw_to:req_cycles", reqc, 16);
    retire(4);
    #1;
    chk("lw_to:ready_after", inst_ready, 1);

    // LW completing in the last permitted cycle
    issue(32'h0000A183, 32'h410, "lw_last", 0, 0, 0, 18);
    q = 32'h1000;
    tick();
    repeat (15) tick();
    mem_valid = 1'b1;
    #1;
    chk("lw_last:req", mem_req, 1);
    chk("lw_last:rf", rf_enable, 1);
    chk("lw_last:trap", trap, 0);
    tick(); mem_valid = 1'b0; retire(4);

    // All-zero word is an illegal opcode
    issue(32'h00000000, 32'h414, "zero", 1, 0, 0, 2);
    tick(); retire(4);

    // ADDI x0,x0,1 must not write
    issue(32'h00100013, 32'h418, "x0", 0, 0, 0, 2);
    #1;
    chk("x0:rf", rf_enable, 0);
    tick(); retire(4);

    // Asynchronous reset in the middle of a memory access
    #1;
    inst_valid = 1'b1; inst = 32'h0000A183; pc = 32'h41C;
    tick();
    inst_valid = 1'b0; q = 32'h1000;
    tick();
    #1;
    chk("arst:req_before", mem_req, 1);
    rst = 1'b0;
    #1;
    chk("arst:req_async", mem_req, 0);
    chk("arst:ready_in_rst", inst_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("arst:ready", inst_ready, 1);
    chk("arst:req", mem_req, 0);
    chk("arst:taken", branch_taken, 0);
    chk("arst:new_pc", new_pc, 0);

    chk("sb:drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
